// File: rtl/baudgen_pkg.sv
// Shared widths and the shadow-configuration record for the baud tick generator.
package baudgen_pkg;

  localparam int DVSR_W_DEF = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVS_W_DEF  = 5;

  typedef struct packed {
    logic [DVSR_W_DEF-1:0] dvsr;
    logic [FRAC_W_DEF-1:0] frac;
    logic [OVS_W_DEF-1:0]  ovs;
  } baudgen_cfg_t;

endpackage

// File: rtl/baud_tick_generator_n_if.sv
// Config/enable inputs and tick outputs of one baud generator channel.
interface baud_tick_generator_n_if #(
  parameter int DVSR_W = baudgen_pkg::DVSR_W_DEF,
  parameter int FRAC_W = baudgen_pkg::FRAC_W_DEF,
  parameter int OVS_W  = baudgen_pkg::OVS_W_DEF
);
  logic              i_en;
  logic              i_load;
  logic [DVSR_W-1:0] i_dvsr;
  logic [FRAC_W-1:0] i_frac;
  logic [OVS_W-1:0]  i_ovs;
  logic              o_sample_tick;
  logic              o_bit_tick;
  logic              o_mid_tick;
  logic [OVS_W-1:0]  o_phase;

  modport master (
    output i_en, i_load, i_dvsr, i_frac, i_ovs,
    input  o_sample_tick, o_bit_tick, o_mid_tick, o_phase
  );

  modport slave (
    input  i_en, i_load, i_dvsr, i_frac, i_ovs,
    output o_sample_tick, o_bit_tick, o_mid_tick, o_phase
  );
endinterface

// File: rtl/baud_frac_accum.sv
// Fractional-divisor accumulator: flags that the next sample period needs one extra clock.
module baud_frac_accum #(
  parameter int FRAC_W = baudgen_pkg::FRAC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_wrap,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_stretch
);
  logic [FRAC_W:0] acc_q;
  logic [FRAC_W:0] acc_d;

  // Next accumulator value: carry bit is dropped before each add and becomes the stretch flag.
  always_comb begin
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_wrap) begin
      acc_d = {1'b0, acc_q[FRAC_W-1:0]} + {1'b0, i_frac};
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_stretch = acc_q[FRAC_W];
endmodule

// File: rtl/baud_tick_generator_n.sv
// Programmable baud tick generator: sample, bit and mid-bit ticks plus phase index.
// Define BAUDGEN_FRAC_EN to enable the fractional divider.
module baud_tick_generator_n
  import baudgen_pkg::*;
#(
  parameter int DVSR_W = DVSR_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVS_W  = OVS_W_DEF
) (
  input logic                    i_clk,
  input logic                    i_rst,
  baud_tick_generator_n_if.slave bus
);
  baudgen_cfg_t      cfg_q, cfg_d;
  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic [OVS_W-1:0]  phase_q, phase_d;
  logic              sample_q, sample_d;
  logic              bit_q, bit_d;
  logic              mid_q, mid_d;

  logic              advance_s;
  logic              at_top_s;
  logic              terminal_s;
  logic              extend_s;
  logic              wrap_s;
  logic [OVS_W-1:0]  phase_nxt_s;
  logic [OVS_W:0]    mid_idx_s;

  assign advance_s   = bus.i_en & ~bus.i_load;
  assign at_top_s    = (cnt_q == cfg_q.dvsr);
  assign wrap_s      = advance_s & terminal_s;
  assign phase_nxt_s = (phase_q == cfg_q.ovs) ? {OVS_W{1'b0}} : (phase_q + OVS_W'(1));
  // Extra bit so that an all-ones ovs does not overflow the midpoint.
  assign mid_idx_s   = ({1'b0, cfg_q.ovs} + (OVS_W+1)'(1)) >> 1;

`ifdef BAUDGEN_FRAC_EN
  logic stretch_s;
  logic extra_q, extra_d;

  baud_frac_accum #(.FRAC_W(FRAC_W)) u_frac_accum (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (bus.i_load),
    .i_wrap    (wrap_s),
    .i_frac    (cfg_q.frac),
    .o_stretch (stretch_s)
  );

  // The stretch clock is a hold at the top count, so an all-ones dvsr never overflows cnt.
  assign terminal_s = at_top_s & (~stretch_s | extra_q);
  assign extend_s   = at_top_s & ~terminal_s;

  // Tracks whether the stretch clock of this period has been spent.
  always_comb begin
    extra_d = extra_q;
    if (bus.i_load || wrap_s) begin
      extra_d = 1'b0;
    end else if (advance_s && extend_s) begin
      extra_d = 1'b1;
    end else begin
      extra_d = extra_q;
    end
  end

  // Stretch-spent flag register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      extra_q <= 1'b0;
    end else begin
      extra_q <= extra_d;
    end
  end
`else
  logic unused_frac_s;

  assign terminal_s    = at_top_s;
  assign extend_s      = 1'b0;
  assign unused_frac_s = ^cfg_q.frac;
`endif

  // Next-state for shadow config, counters and ticks; load wins over enable.
  always_comb begin
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    sample_d = 1'b0;
    bit_d    = 1'b0;
    mid_d    = 1'b0;
    if (bus.i_load) begin
      cfg_d   = '{dvsr: bus.i_dvsr, frac: bus.i_frac, ovs: bus.i_ovs};
      cnt_d   = '0;
      phase_d = '0;
    end else if (advance_s) begin
      if (terminal_s) begin
        cnt_d    = '0;
        phase_d  = phase_nxt_s;
        sample_d = 1'b1;
        bit_d    = (phase_q == cfg_q.ovs);
        mid_d    = (cfg_q.ovs != {OVS_W{1'b0}}) && ({1'b0, phase_nxt_s} == mid_idx_s);
      end else if (extend_s) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + DVSR_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and registered tick outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cfg_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= '0;
      sample_q <= 1'b0;
      bit_q    <= 1'b0;
      mid_q    <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      mid_q    <= mid_d;
    end
  end

  assign bus.o_sample_tick = sample_q;
  assign bus.o_bit_tick    = bit_q;
  assign bus.o_mid_tick    = mid_q;
  assign bus.o_phase       = phase_q;
endmodule

// File: tb/tb_baud_tick_generator_n.sv
// Directed, table-driven bench for baud_tick_generator_n (covers BAUDGEN_FRAC_EN builds too).
module tb_baud_tick_generator_n;

  typedef struct {
    string       name;
    logic [15:0] dvsr;
    logic [3:0]  frac;
    logic [4:0]  ovs;
    int          ncyc;
    int          exp_s;
    int          exp_b;
    int          exp_m;
    logic [4:0]  exp_ph;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  baud_tick_generator_n_if #(.DVSR_W(16), .FRAC_W(4), .OVS_W(5)) bus_if ();

  baud_tick_generator_n dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] f, input logic [4:0] o);
    bus_if.i_dvsr = d;
    bus_if.i_frac = f;
    bus_if.i_ovs  = o;
    bus_if.i_load = 1'b1;
    cyc();
    bus_if.i_load = 1'b0;
  endtask

  vec_t vecs[$];
  int   tick_at[$];
  int   exp_at[5];

  initial begin
    int s_cnt, b_cnt, m_cnt, k;
    logic any_tick;
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_fail = 0;
    bus_if.i_en = 1'b0;
    bus_if.i_load = 1'b0;
    bus_if.i_dvsr = 16'd0;
    bus_if.i_frac = 4'd0;
    bus_if.i_ovs = 5'd0;

    vecs.push_back('{"x16_dvsr3",   16'd3,      4'd0, 5'd15, 64,    16, 1,  1, 5'd0});
    vecs.push_back('{"dvsr0_ovs0",  16'd0,      4'd0, 5'd0,  10,    10, 10, 0, 5'd0});
    vecs.push_back('{"dvsr4_ovs3",  16'd4,      4'd0, 5'd3,  50,    10, 2,  3, 5'd2});
    vecs.push_back('{"dvsr1_ovs2",  16'd1,      4'd0, 5'd2,  7,     3,  1,  1, 5'd0});
    vecs.push_back('{"frac0_dvsr9", 16'd9,      4'd0, 5'd1,  100,   10, 5,  5, 5'd0});
`ifdef BAUDGEN_FRAC_EN
    vecs.push_back('{"frac8_dvsr9", 16'd9,      4'd8, 5'd15, 61,    5,  0,  0, 5'd5});
`else
    vecs.push_back('{"frac8_dvsr9", 16'd9,      4'd8, 5'd15, 61,    6,  0,  0, 5'd6});
`endif
    vecs.push_back('{"dvsr_ones",   16'hFFFF,   4'd0, 5'd0,  65536, 1,  1,  0, 5'd0});

    // Reset state and reset configuration (tick every enabled clock)
    #12;
    check("reset_outputs", {bus_if.o_sample_tick, bus_if.o_bit_tick, bus_if.o_mid_tick, bus_if.o_phase}, 32'd0);
    rst = 1'b0;
    bus_if.i_en = 1'b1;
    cyc();
    check("rstcfg_sample1", bus_if.o_sample_tick, 32'd1);
    check("rstcfg_bit1", bus_if.o_bit_tick, 32'd1);
    check("rstcfg_mid1", bus_if.o_mid_tick, 32'd0);
    cyc();
    check("rstcfg_sample2", bus_if.o_sample_tick, 32'd1);

    // Table-driven: load config, run N enabled clocks, count ticks
    foreach (vecs[i]) begin
      bus_if.i_en = 1'b0;
      do_load(vecs[i].dvsr, vecs[i].frac, vecs[i].ovs);
      check({vecs[i].name, "_load"}, {bus_if.o_sample_tick, bus_if.o_phase}, 32'd0);
      bus_if.i_en = 1'b1;
      s_cnt = 0;
      b_cnt = 0;
      m_cnt = 0;
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        cyc();
        s_cnt += int'(bus_if.o_sample_tick);
        b_cnt += int'(bus_if.o_bit_tick);
        m_cnt += int'(bus_if.o_mid_tick);
      end
      check({vecs[i].name, "_samples"}, s_cnt, vecs[i].exp_s);
      check({vecs[i].name, "_bits"}, b_cnt, vecs[i].exp_b);
      check({vecs[i].name, "_mids"}, m_cnt, vecs[i].exp_m);
      check({vecs[i].name, "_phase"}, bus_if.o_phase, vecs[i].exp_ph);
    end

    // Fractional tick timing: cycles from load to each of the first five ticks
`ifdef BAUDGEN_FRAC_EN
    exp_at = '{10, 20, 31, 41, 52};
`else
    exp_at = '{10, 20, 30, 40, 50};
`endif
    bus_if.i_en = 1'b0;
    do_load(16'd9, 4'd8, 5'd15);
    bus_if.i_en = 1'b1;
    tick_at.delete();
    for (int c = 1; c <= 60; c++) begin
      cyc();
      if (bus_if.o_sample_tick) tick_at.push_back(c);
    end
    for (int t = 0; t < 5; t++) begin
      check($sformatf("frac_tick%0d_cycle", t), (t < tick_at.size()) ? tick_at[t] : -1, exp_at[t]);
    end

    // Enable low for 5 clocks mid-period: tick delayed by exactly 5, phase frozen
    bus_if.i_en = 1'b0;
    do_load(16'd7, 4'd0, 5'd15);
    bus_if.i_en = 1'b1;
    repeat (3) cyc();
    bus_if.i_en = 1'b0;
    any_tick = 1'b0;
    repeat (5) begin
      cyc();
      any_tick |= bus_if.o_sample_tick;
    end
    check("en_low_no_tick", any_tick, 32'd0);
    check("en_low_phase", bus_if.o_phase, 32'd0);
    bus_if.i_en = 1'b1;
    k = 0;
    for (int c = 1; c <= 40 && k == 0; c++) begin
      cyc();
      if (bus_if.o_sample_tick) k = c;
    end
    check("en_resume_delay", k, 32'd5);
    check("en_resume_phase", bus_if.o_phase, 32'd1);

    // Reload mid-count from dvsr=100 to dvsr=1
    do_load(16'd100, 4'd0, 5'd3);
    repeat (30) cyc();
    do_load(16'd1, 4'd0, 5'd3);
    check("reload_no_tick", bus_if.o_sample_tick, 32'd0);
    check("reload_phase0", bus_if.o_phase, 32'd0);
    cyc();
    check("reload_tick_c1", bus_if.o_sample_tick, 32'd0);
    cyc();
    check("reload_tick_c2", bus_if.o_sample_tick, 32'd1);
    check("reload_phase_c2", bus_if.o_phase, 32'd1);

    // Async reset between edges while a tick is showing
    do_load(16'd5, 4'd0, 5'd3);
    repeat (12) cyc();
    check("pre_rst_tick", bus_if.o_sample_tick, 32'd1);
    check("pre_rst_phase", bus_if.o_phase, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {bus_if.o_sample_tick, bus_if.o_bit_tick, bus_if.o_mid_tick, bus_if.o_phase}, 32'd0);
    #2 rst = 1'b0;
    cyc();
    check("post_rst_sample", bus_if.o_sample_tick, 32'd1);
    check("post_rst_bit", bus_if.o_bit_tick, 32'd1);
    check("post_rst_phase", bus_if.o_phase, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
